// File: rtl/interrupt_unit_pkg.sv
// Shared processor definitions for the interrupt sequencer: state encoding,
// PC width, default vector and the state-to-strobe decode.
package interrupt_unit_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] DEFAULT_VECTOR = 32'd12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_PUSH_PC  = 3'd2,
    ST_PUSH_FLG = 3'd3,
    ST_VECTOR   = 3'd4,
    ST_SERVICE  = 3'd5
  } state_e;

  typedef struct packed {
    logic fetch_hold;
    logic flush;
    logic push_pc;
    logic push_flags;
    logic pc_select_int;
    logic int_ack;
    logic in_service;
  } ctrl_t;

  // Moore decode: every pipeline strobe is a pure function of the state.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_DRAIN: c.fetch_hold = 1'b1;
      ST_PUSH_PC: begin
        c.fetch_hold = 1'b1;
        c.flush      = 1'b1;
        c.push_pc    = 1'b1;
      end
      ST_PUSH_FLG: begin
        c.fetch_hold = 1'b1;
        c.flush      = 1'b1;
        c.push_flags = 1'b1;
      end
      ST_VECTOR: begin
        c.pc_select_int = 1'b1;
        c.int_ack       = 1'b1;
        c.flush         = 1'b1;
      end
      ST_SERVICE: c.in_service = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/interrupt_unit_edge_detect.sv
// Rising-edge detector for an asynchronous-level external pin already in the
// clk domain; reusable for any level-sensitive request line.
module int_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic rise_o
);

  logic pin_q;

  always_ff @(posedge clk) begin
    if (rst) pin_q <= 1'b0;
    else     pin_q <= pin_i;
  end

  assign rise_o = pin_i & ~pin_q;

endmodule

// File: rtl/interrupt_unit.sv
// Interrupt entry/return sequencer: drain, push epc, push flags, vector, serve.
// Optional macro INT_PENDING_EN latches one request arriving while busy.
module interrupt_unit
  import interrupt_unit_pkg::*;
#(
  parameter int              DRAIN_CYCLES = 3,
  parameter logic [PC_W-1:0] VECTOR_ADDR  = DEFAULT_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            int_req,
  input  logic [PC_W-1:0] pc_in,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            ret_int,
  output logic            fetch_hold,
  output logic            flush,
  output logic            push_pc,
  output logic            push_flags,
  output logic            pc_select_int,
  output logic [PC_W-1:0] vector_addr,
  output logic [PC_W-1:0] epc,
  output logic            int_ack,
  output logic            in_service,
  output state_e          dbg_state
);

  localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYCLES - 1);

  logic            rise;
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] epc_q, epc_d;
  ctrl_t           ctrl_q;

  int_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (int_req),
    .rise_o (rise)
  );

`ifdef INT_PENDING_EN
  logic pend_q, pend_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
`ifdef INT_PENDING_EN
    pend_d  = pend_q;
    if (rise && state_q != ST_IDLE) pend_d = 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_DRAIN;
          epc_d   = pc_in;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_DRAIN: begin
        // A late redirect replaces the return address: it is where fetch would have gone.
        if (redirect_valid) epc_d = redirect_pc;
        if (cnt_q == 4'd0) state_d = ST_PUSH_PC;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_PUSH_PC:  state_d = ST_PUSH_FLG;
      ST_PUSH_FLG: state_d = ST_VECTOR;
      ST_VECTOR:   state_d = ST_SERVICE;
      ST_SERVICE: begin
        if (ret_int) begin
`ifdef INT_PENDING_EN
          // A rise coinciding with ret_int is treated as already pending.
          if (pend_q || rise) begin
            state_d = ST_DRAIN;
            epc_d   = pc_in;
            cnt_d   = CNT_LOAD;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      epc_q   <= '0;
      ctrl_q  <= '0;
`ifdef INT_PENDING_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      ctrl_q  <= decode_ctrl(state_d);
`ifdef INT_PENDING_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign fetch_hold    = ctrl_q.fetch_hold;
  assign flush         = ctrl_q.flush;
  assign push_pc       = ctrl_q.push_pc;
  assign push_flags    = ctrl_q.push_flags;
  assign pc_select_int = ctrl_q.pc_select_int;
  assign int_ack       = ctrl_q.int_ack;
  assign in_service    = ctrl_q.in_service;
  assign vector_addr   = VECTOR_ADDR;
  assign epc           = epc_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_interrupt_unit.sv
// Bench for interrupt_unit with default parameters; INT_PENDING_EN selects
// the expected behaviour of a request arriving during service.
module tb_interrupt_unit;
  import interrupt_unit_pkg::*;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_req = 1'b0;
  logic [31:0] pc_in = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ret_int = 1'b0;
  logic        fetch_hold, flush, push_pc, push_flags, pc_select_int;
  logic        int_ack, in_service;
  logic [31:0] vector_addr, epc;
  state_e      dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = '0;
  logic [63:0] exp_q[$];
  logic [6:0]  seq_exp [1:7];
  logic [6:0]  obs;

  interrupt_unit dut (
    .clk(clk), .rst(rst), .int_req(int_req), .pc_in(pc_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ret_int(ret_int),
    .fetch_hold(fetch_hold), .flush(flush), .push_pc(push_pc), .push_flags(push_flags),
    .pc_select_int(pc_select_int), .vector_addr(vector_addr), .epc(epc),
    .int_ack(int_ack), .in_service(in_service), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  assign obs = {fetch_hold, flush, push_pc, push_flags, pc_select_int, int_ack, in_service};

  // Scoreboard: each push_pc must match the next expected {cycle, epc}.
  always @(negedge clk) begin
    logic [63:0] ent;
    if (push_pc === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_push: unexpected push_pc at cycle %0d epc=%h", cyc, epc);
      end else begin
        ent = exp_q.pop_front();
        if (ent[63:32] !== cyc || ent[31:0] !== epc) begin
          errors++;
          $display("FAIL sb_push: got cycle %0d epc %h, expected cycle %0d epc %h",
                   cyc, epc, ent[63:32], ent[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [31:0] pc, input logic [31:0] exp_epc);
    pc_in   = pc;
    int_req = 1'b1;
    exp_q.push_back({cyc + 32'd1 + 32'(D), exp_epc});
    tick();
  endtask

  task automatic wait_state(input state_e s, input int budget, input string name);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (dbg_state !== s) begin
      errors++;
      $display("FAIL %s: state %0d, expected %0d within %0d cycles", name, dbg_state, s, budget);
    end
  endtask

  task automatic do_return(input string name);
    ret_int = 1'b1;
    tick();
    ret_int = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE || in_service !== 1'b0) begin
      errors++;
      $display("FAIL %s: state %0d in_service %b, expected IDLE/0", name, dbg_state, in_service);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 7'b0 || epc !== 32'h0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset: obs %b epc %h state %0d, expected 0/0/IDLE", obs, epc, dbg_state);
    end
    checks++;
    if (vector_addr !== 32'd12) begin
      errors++;
      $display("FAIL vector_addr: got %h expected %h", vector_addr, 32'd12);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    start_req(32'h40, 32'h40);
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (obs !== seq_exp[k]) begin
        errors++;
        $display("FAIL basic_seq[%0d]: got %b expected %b", k, obs, seq_exp[k]);
      end
      if (k == 1) pc_in = 32'h99;
      if (k < 7) tick();
    end
    checks++;
    if (epc !== 32'h40) begin
      errors++;
      $display("FAIL basic_epc: got %h expected %h", epc, 32'h40);
    end
    int_req = 1'b0;
    do_return("basic_ret");
  endtask

  task automatic test_redirect();
    start_req(32'h200, 32'h80);
    int_req = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    wait_state(ST_PUSH_PC, 6, "redir_wait_push");
    checks++;
    if (epc !== 32'h80) begin
      errors++;
      $display("FAIL redir_epc: got %h expected %h", epc, 32'h80);
    end
    wait_state(ST_SERVICE, 6, "redir_wait_service");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h123;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (epc !== 32'h80) begin
      errors++;
      $display("FAIL redir_outside: got %h expected %h", epc, 32'h80);
    end
    do_return("redir_ret");
  endtask

  task automatic test_pending();
    int strobes = 0;
    start_req(32'h300, 32'h300);
    int_req = 1'b0;
    wait_state(ST_SERVICE, 12, "pend_wait_service");
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    pc_in   = 32'h444;
`ifdef INT_PENDING_EN
    exp_q.push_back({cyc + 32'd1 + 32'(D), 32'h444});
    ret_int = 1'b1;
    tick();
    ret_int = 1'b0;
    checks++;
    if (dbg_state !== ST_DRAIN) begin
      errors++;
      $display("FAIL pend_drain: state %0d expected %0d", dbg_state, ST_DRAIN);
    end
    for (int i = 0; i < D; i++) tick();
    checks++;
    if (push_pc !== 1'b1) begin
      errors++;
      $display("FAIL pend_push: push_pc %b expected 1", push_pc);
    end
    wait_state(ST_SERVICE, 6, "pend_wait_service2");
    do_return("pend_ret");
`else
    do_return("nopend_ret");
    for (int i = 0; i < 8; i++) begin
      if (obs !== 7'b0) strobes++;
      tick();
    end
    checks++;
    if (strobes != 0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL nopend_quiet: %0d active cycles state %0d, expected 0 and IDLE", strobes, dbg_state);
    end
`endif
  endtask

  task automatic test_hold();
    int acks = 0;
    start_req(32'h500, 32'h500);
    for (int i = 0; i < 19; i++) begin
      if (int_ack === 1'b1) acks++;
      tick();
    end
    int_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (int_ack === 1'b1) acks++;
      tick();
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL hold_acks: got %0d expected 1", acks);
    end
    do_return("hold_ret");
  endtask

  task automatic test_rst_mid();
    start_req(32'h600, 32'h600);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (dbg_state !== ST_PUSH_FLG) begin
      errors++;
      $display("FAIL rst_mid_pos: state %0d expected %0d", dbg_state, ST_PUSH_FLG);
    end
    rst     = 1'b1;
    int_req = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if (obs !== 7'b0 || epc !== 32'h0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_mid: obs %b epc %h state %0d, expected 0/0/IDLE", obs, epc, dbg_state);
    end
    ret_int = 1'b1;
    tick();
    ret_int = 1'b0;
    tick();
    checks++;
    if (obs !== 7'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL ret_idle: obs %b state %0d, expected 0/IDLE", obs, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    for (int it = 0; it < 4; it++) begin
      pc = $urandom;
      start_req(pc, pc);
      int_req = 1'b0;
      pc_in   = $urandom;
      wait_state(ST_SERVICE, 10, "b2b_wait_service");
      checks++;
      if (epc !== pc) begin
        errors++;
        $display("FAIL b2b_epc[%0d]: got %h expected %h", it, epc, pc);
      end
      do_return("b2b_ret");
      for (int j = 0; j < $urandom_range(0, 2); j++) tick();
    end
  endtask

  initial begin
    seq_exp[1] = 7'b1000000;
    seq_exp[2] = 7'b1000000;
    seq_exp[3] = 7'b1000000;
    seq_exp[4] = 7'b1110000;
    seq_exp[5] = 7'b1101000;
    seq_exp[6] = 7'b0100110;
    seq_exp[7] = 7'b0000001;
    test_reset();
    test_basic();
    test_redirect();
    test_pending();
    test_hold();
    test_rst_mid();
    test_back_to_back();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected push_pc events never seen", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_unit.md
# interrupt_unit

Sequencer that converts an external interrupt pin into the pipeline actions needed to enter an interrupt service routine. Sits upstream of the fetch stage and beside the memory stage. It drains in-flight work while fetch is held, then has the memory stage push the return PC and the flags, then steers fetch to the interrupt vector. It tracks in-service state until decode reports a return-from-interrupt.

## Interface
Parameters:
- DRAIN_CYCLES, 3: cycles fetch is held so instructions already in flight retire; legal range 1..15.
- VECTOR_ADDR, 32'd12: fetch target when entering the ISR.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- int_req  in  1  external interrupt pin, level; a 0->1 transition is one request.
- pc_in  in  32  PC of the next instruction fetch would issue.
- redirect_valid  in  1  branch/call/return redirect resolved this cycle.
- redirect_pc  in  32  target of that redirect.
- ret_int  in  1  decode has an RTI instruction this cycle.
- fetch_hold  out  1  freeze PC and the fetch/decode buffer.
- flush  out  1  squash the fetch/decode buffer contents.
- push_pc  out  1  memory stage pushes the 32-bit epc to the stack.
- push_flags  out  1  memory stage pushes the flags word.
- pc_select_int  out  1  fetch loads vector_addr.
- vector_addr  out  32  constant VECTOR_ADDR.
- epc  out  32  latched return PC.
- int_ack  out  1  one-cycle acknowledge.
- in_service  out  1  ISR active.

## Operation
- Edge detection: int_req_q <= int_req each cycle. rise = int_req & ~int_req_q.
- States: IDLE, DRAIN, PUSH_PC, PUSH_FLG, VECTOR, SERVICE.
- IDLE: on rise, go to DRAIN, epc <= pc_in, cnt <= DRAIN_CYCLES-1.
- DRAIN: fetch_hold=1. If redirect_valid, epc <= redirect_pc (the last redirect wins). When cnt==0, go to PUSH_PC; otherwise cnt decrements.
- PUSH_PC: fetch_hold=1, flush=1, push_pc=1. Go to PUSH_FLG.
- PUSH_FLG: fetch_hold=1, flush=1, push_flags=1. Go to VECTOR.
- VECTOR: pc_select_int=1, int_ack=1, flush=1. Go to SERVICE.
- SERVICE: in_service=1. On ret_int, go to IDLE, or to DRAIN if a request is pending (see Configuration).
- ret_int outside SERVICE is ignored.
- redirect_valid outside DRAIN does not alter epc.
- rise outside IDLE is handled per Configuration.
- A rise in the same cycle as ret_int in SERVICE counts as arriving during SERVICE.
- All outputs except epc and vector_addr are Moore outputs, decoded from state only.
- Reset values: state IDLE, cnt 0, int_req_q 0, epc 0, every 1-bit output 0.
- rst mid-sequence returns to IDLE at once. The pending flag is cleared.

## Timing
- rise sampled at edge E: DRAIN occupies cycles E+1 .. E+DRAIN_CYCLES.
- push_pc is high in cycle E+DRAIN_CYCLES+1 and push_flags in +2. pc_select_int and int_ack are high in +3. in_service goes high from +4.
- Entry latency with default parameters: 7 cycles from the pin edge to the first ISR fetch.
- Each push/vector strobe is exactly one cycle wide.
- epc is stable from the start of PUSH_PC until the next DRAIN entry.
- Return latency: ret_int at edge R puts the unit in IDLE, or in DRAIN, during cycle R+1.

## Configuration
- INT_PENDING_EN defined:
  - A rise in any non-IDLE state sets a pending flag. The flag holds at most one request; extra rises are lost.
  - On ret_int in SERVICE with pending set: go to DRAIN, clear pending, epc <= pc_in.
  - A rise while in IDLE with pending already set is impossible, because pending is consumed on exit from SERVICE.
- INT_PENDING_EN undefined: a rise outside IDLE is dropped and no pending register exists.

## Structure
- The shared processor package holds:
  - the state enum (3-bit);
  - the default vector constant 32'd12;
  - the width constant for the 32-bit PC.
- One sub-module, int_edge_detect: the int_req_q register and rise output. It is reusable for other external pins.
- The FSM, drain counter, epc and pending registers live in interrupt_unit.

## Test plan
- Reset, then int_req rises at cycle 10 with pc_in=0x40 -> push_pc at cycle 14, push_flags at 15, pc_select_int/int_ack at 16, in_service from 17, epc=0x40.
- Rise with redirect_valid=1, redirect_pc=0x80 in the second DRAIN cycle -> epc=0x80 at PUSH_PC.
- In SERVICE, pulse ret_int -> in_service low and state IDLE the next cycle. A later rise produces a full sequence again.
- Second rise during SERVICE:
  - with INT_PENDING_EN: ret_int -> immediate DRAIN, push_pc 4 cycles later;
  - without it: IDLE and no strobes.
- Hold int_req high for 20 cycles -> exactly one int_ack.
- Assert rst during PUSH_FLG -> all outputs 0 and epc 0 the next cycle; ret_int in IDLE produces no effect.
